alu_control_pipe: RTL and testbench

Parametrised successor to the combinational ALU control decoder. It decodes Opcode/Funct in ID into an ALU operation code and registers it into the ID/EX slot, with valid and flush handling. It also sequences multi-cycle MUL/DIV operations, asserting Busy so the hazard unit stalls ID, and pulsing Done on completion. It sits between the ID-stage decoder and the EX-stage ALU/multiplier.

---
 rtl/alu_ctrl_pkg.sv | 60 ++++++
 rtl/alu_op_decode.sv | 52 +++++
 rtl/alu_control_pipe.sv | 97 +++++++++
 tb/tb_alu_control_pipe.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control pipeline: ALU op codes, MIPS opcode/funct
// values and FSM state encodings.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_MUL = 4'b0011;
  localparam logic [3:0] ALU_DIV = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  localparam logic [5:0] OP_RTYPE   = 6'b000000;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_SLTI    = 6'b001010;
  localparam logic [5:0] OP_SLTIU   = 6'b001011;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] OP_LB      = 6'b100000;
  localparam logic [5:0] OP_LH      = 6'b100001;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SB      = 6'b101000;
  localparam logic [5:0] OP_SH      = 6'b101001;
  localparam logic [5:0] OP_SW      = 6'b101011;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SLLV  = 6'b000100;
  localparam logic [5:0] FN_SRLV  = 6'b000110;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;
  localparam logic [5:0] FN2_MUL  = 6'b000010;

  localparam logic S_IDLE = 1'b0;
  localparam logic S_BUSY = 1'b1;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational Opcode/Funct to ALU op decoder; also flags MUL/DIV class and
// undecoded instructions. Shared with the ID-stage decoder.
module alu_op_decode
  import alu_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] aluop,
  output logic       is_multi,
  output logic       is_div,
  output logic       illegal
);

  always_comb begin
    aluop   = ALU_ADD;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU:             aluop = ALU_ADD;
          FN_SUB, FN_SUBU:             aluop = ALU_SUB;
          FN_AND:                      aluop = ALU_AND;
          FN_OR:                       aluop = ALU_OR;
          FN_NOR:                      aluop = ALU_NOR;
          FN_XOR:                      aluop = ALU_XOR;
          FN_SLT, FN_SLTU:             aluop = ALU_SLT;
          FN_SLL, FN_SLLV:             aluop = ALU_SLL;
          FN_SRL, FN_SRLV:             aluop = ALU_SRL;
          FN_MULT, FN_MULTU:           aluop = ALU_MUL;
          FN_DIV, FN_DIVU:             aluop = ALU_DIV;
          default:                     illegal = 1'b1;
        endcase
      end
      OP_SPECIAL2: begin
        if (funct == FN2_MUL) aluop = ALU_MUL;
        else                  illegal = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW,
      OP_LB, OP_SB, OP_LH, OP_SH:      aluop = ALU_ADD;
      OP_ANDI:                         aluop = ALU_AND;
      OP_ORI:                          aluop = ALU_OR;
      OP_XORI:                         aluop = ALU_XOR;
      OP_SLTI, OP_SLTIU:               aluop = ALU_SLT;
      OP_BEQ, OP_BNE, OP_BGTZ, OP_BLEZ: aluop = ALU_SUB;
      default:                         illegal = 1'b1;
    endcase
  end

  assign is_div   = (aluop == ALU_DIV);
  assign is_multi = (aluop == ALU_MUL) || is_div;

endmodule

// File: rtl/alu_control_pipe.sv
// ID/EX ALU control register with MUL/DIV busy sequencing and flush handling.
// Optional ALUCTL_ILLEGAL_EN adds a registered ExIllegal flag for undecoded ops.
module alu_control_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [5:0]         Opcode,
  input  logic [5:0]         Funct,
  input  logic               IdValid,
  input  logic               Flush,
  output logic [ALUOP_W-1:0] ExALUOp,
  output logic               ExValid,
  output logic               ExMultiCycle,
  output logic               Busy,
  output logic               Done
`ifdef ALUCTL_ILLEGAL_EN
  ,
  output logic               ExIllegal
`endif
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  logic             state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       dec_op;
  logic             dec_multi;
  logic             dec_div;
  logic             dec_illegal;

  alu_op_decode u_decode (
    .opcode   (Opcode),
    .funct    (Funct),
    .aluop    (dec_op),
    .is_multi (dec_multi),
    .is_div   (dec_div),
    .illegal  (dec_illegal)
  );

  assign Busy = (state == S_BUSY);
  // A flush in the last busy cycle aborts the op, so it must not report completion.
  assign Done = Busy && (cnt == '0) && !Flush;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ExALUOp      <= '0;
      ExValid      <= 1'b0;
      ExMultiCycle <= 1'b0;
      state        <= S_IDLE;
      cnt          <= '0;
    end else if (Flush) begin
      ExValid      <= 1'b0;
      ExMultiCycle <= 1'b0;
      state        <= S_IDLE;
      cnt          <= '0;
    end else if (state == S_BUSY) begin
      if (cnt == '0) begin
        state        <= S_IDLE;
        ExValid      <= 1'b0;
        ExMultiCycle <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end else if (IdValid) begin
      ExALUOp      <= ALUOP_W'(dec_op);
      ExValid      <= 1'b1;
      ExMultiCycle <= dec_multi;
      if (dec_multi) begin
        state <= S_BUSY;
        cnt   <= dec_div ? DIV_LOAD : MUL_LOAD;
      end
    end else begin
      ExValid      <= 1'b0;
      ExMultiCycle <= 1'b0;
    end
  end

`ifdef ALUCTL_ILLEGAL_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                              ExIllegal <= 1'b0;
    else if (Flush)                         ExIllegal <= 1'b0;
    else if (state == S_IDLE && IdValid)    ExIllegal <= dec_illegal;
  end
`else
  logic unused_illegal;
  assign unused_illegal = dec_illegal;
`endif

endmodule

// File: tb/tb_alu_control_pipe.sv
// Self-checking bench for alu_control_pipe: directed scenarios plus random
// traffic against a cycle-level behavioural model.
module tb_alu_control_pipe;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 8;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       IdValid;
  logic       Flush;
  logic [3:0] ExALUOp;
  logic       ExValid;
  logic       ExMultiCycle;
  logic       Busy;
  logic       Done;
`ifdef ALUCTL_ILLEGAL_EN
  logic       ExIllegal;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  alu_control_pipe #(.ALUOP_W(4), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Opcode       (Opcode),
    .Funct        (Funct),
    .IdValid      (IdValid),
    .Flush        (Flush),
    .ExALUOp      (ExALUOp),
    .ExValid      (ExValid),
    .ExMultiCycle (ExMultiCycle),
    .Busy         (Busy),
    .Done         (Done)
`ifdef ALUCTL_ILLEGAL_EN
    ,
    .ExIllegal    (ExIllegal)
`endif
  );

  // Reference model: m_left counts remaining busy cycles of a MUL/DIV op.
  logic [3:0] m_op;
  bit         m_valid, m_multi, m_ill;
  int         m_left;

  wire [7:0] dut_pkt = {ExALUOp, ExValid, ExMultiCycle, Busy, Done};

  function automatic logic [4:0] ref_dec(input logic [5:0] opc, input logic [5:0] fn);
    case (opc)
      6'b000000: begin
        case (fn)
          6'b100000, 6'b100001: return 5'b0_0010;
          6'b100010, 6'b100011: return 5'b0_0110;
          6'b100100:            return 5'b0_0000;
          6'b100101:            return 5'b0_0001;
          6'b100111:            return 5'b0_1100;
          6'b100110:            return 5'b0_1101;
          6'b101010, 6'b101011: return 5'b0_0111;
          6'b000000, 6'b000100: return 5'b0_1000;
          6'b000010, 6'b000110: return 5'b0_1001;
          6'b011000, 6'b011001: return 5'b0_0011;
          6'b011010, 6'b011011: return 5'b0_0100;
          default:              return 5'b1_0010;
        endcase
      end
      6'b011100: return (fn == 6'b000010) ? 5'b0_0011 : 5'b1_0010;
      6'b001000, 6'b001001, 6'b100011, 6'b101011,
      6'b100000, 6'b101000, 6'b100001, 6'b101001: return 5'b0_0010;
      6'b001100: return 5'b0_0000;
      6'b001101: return 5'b0_0001;
      6'b001110: return 5'b0_1101;
      6'b001010, 6'b001011: return 5'b0_0111;
      6'b000100, 6'b000101, 6'b000110, 6'b000111: return 5'b0_0110;
      default: return 5'b1_0010;
    endcase
  endfunction

  function automatic logic [7:0] exp_pkt();
    return {m_op, m_valid, m_multi, (m_left > 0), (m_left == 1) && !Flush};
  endfunction

  task automatic model_reset();
    m_op = 4'd0; m_valid = 0; m_multi = 0; m_ill = 0; m_left = 0;
  endtask

  // Apply one cycle of ID inputs, advance the model over the edge, settle 1 time unit.
  task automatic drive(input logic [5:0] opc, input logic [5:0] fn, input logic v, input logic fl);
    logic [4:0] d;
    Opcode = opc; Funct = fn; IdValid = v; Flush = fl;
    @(posedge Clk);
    if (fl) begin
      m_valid = 0; m_multi = 0; m_left = 0; m_ill = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin m_valid = 0; m_multi = 0; end
    end else if (v) begin
      d = ref_dec(opc, fn);
      m_op = d[3:0]; m_ill = d[4]; m_valid = 1;
      m_multi = (d[3:0] == 4'b0011) || (d[3:0] == 4'b0100);
      m_left = (d[3:0] == 4'b0011) ? MUL_LAT : (d[3:0] == 4'b0100) ? DIV_LAT : 0;
    end else begin
      m_valid = 0; m_multi = 0;
    end
    #1;
  endtask

  function automatic logic [5:0] rand_opcode();
    logic [5:0] iops [14];
    int r;
    iops = '{6'b001000, 6'b001001, 6'b100011, 6'b101011, 6'b100000, 6'b001100, 6'b001101,
             6'b001110, 6'b001010, 6'b001011, 6'b000100, 6'b000101, 6'b000110, 6'b000111};
    r = $urandom_range(0, 9);
    if (r < 5)  return 6'b000000;
    if (r == 5) return 6'b011100;
    if (r < 9)  return iops[$urandom_range(0, 13)];
    return 6'($urandom);
  endfunction

  function automatic logic [5:0] rand_funct(input bit single_only);
    logic [5:0] fns [22];
    fns = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101, 6'b100110,
            6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b000110,
            6'b110001, 6'b111111, 6'b011000, 6'b011001, 6'b011010, 6'b011011, 6'b000010,
            6'b011000};
    if (single_only) return fns[$urandom_range(0, 15)];
    if ($urandom_range(0, 9) == 0) return 6'($urandom);
    return fns[$urandom_range(0, 21)];
  endfunction

  task automatic test_reset();
    Reset = 1'b1; Opcode = 0; Funct = 0; IdValid = 0; Flush = 0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    vectors++;
    if (dut_pkt !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_state got=%b exp=%b", dut_pkt, 8'h00);
    end
`ifdef ALUCTL_ILLEGAL_EN
    vectors++;
    if (ExIllegal !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_illegal got=%b exp=0", ExIllegal);
    end
`endif
    #2 Reset = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic test_rtype();
    logic [5:0] fns [6];
    logic [3:0] ops [6];
    fns = '{6'b100011, 6'b100000, 6'b100100, 6'b100111, 6'b101010, 6'b000110};
    ops = '{4'b0110, 4'b0010, 4'b0000, 4'b1100, 4'b0111, 4'b1001};
    for (int i = 0; i < 6; i++) begin
      drive(6'b000000, fns[i], 1'b1, 1'b0);
      vectors++;
      if ({ExALUOp, ExValid, ExMultiCycle, Busy} !== {ops[i], 3'b100}) begin
        miscompares++;
        $display("FAIL rtype_%0d got=%b exp=%b", i, {ExALUOp, ExValid, ExMultiCycle, Busy}, {ops[i], 3'b100});
      end
    end
  endtask

  task automatic test_itype();
    logic [5:0] opcs [3];
    logic [3:0] ops [3];
    opcs = '{6'b001100, 6'b000101, 6'b100011};
    ops  = '{4'b0000, 4'b0110, 4'b0010};
    for (int i = 0; i < 3; i++) begin
      drive(opcs[i], 6'($urandom), 1'b1, 1'b0);
      vectors++;
      if ({ExALUOp, ExValid} !== {ops[i], 1'b1}) begin
        miscompares++;
        $display("FAIL itype_%0d got=%b exp=%b", i, {ExALUOp, ExValid}, {ops[i], 1'b1});
      end
    end
    drive(6'b001100, 6'b000000, 1'b0, 1'b0);
    vectors++;
    if ({ExALUOp, ExValid} !== 5'b0010_0) begin
      miscompares++;
      $display("FAIL itype_novalid got=%b exp=%b", {ExALUOp, ExValid}, 5'b0010_0);
    end
  endtask

  task automatic test_mul();
    drive(6'b000000, 6'b011000, 1'b1, 1'b0);
    for (int k = 0; k < MUL_LAT; k++) begin
      vectors++;
      if ({ExALUOp, ExValid, ExMultiCycle, Busy, Done} !== {4'b0011, 3'b111, (k == MUL_LAT - 1)}) begin
        miscompares++;
        $display("FAIL mul_busy_%0d got=%b exp=%b", k, dut_pkt, {4'b0011, 3'b111, (k == MUL_LAT - 1)});
      end
      drive(6'b000000, 6'b100000, 1'b1, 1'b0);
    end
    vectors++;
    if ({ExALUOp, ExValid, Busy, Done} !== 7'b0011_000) begin
      miscompares++;
      $display("FAIL mul_release got=%b exp=%b", {ExALUOp, ExValid, Busy, Done}, 7'b0011_000);
    end
    drive(6'b000000, 6'b100000, 1'b1, 1'b0);
    vectors++;
    if (dut_pkt !== 8'b0010_1000) begin
      miscompares++;
      $display("FAIL mul_next_accept got=%b exp=%b", dut_pkt, 8'b0010_1000);
    end
  endtask

  task automatic test_flush();
    bit saw_done = 0;
    drive(6'b000000, 6'b011010, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      saw_done |= Done;
      drive(6'b000000, 6'b000000, 1'b0, 1'b0);
    end
    Flush = 1'b1; #1;
    saw_done |= Done;
    drive(6'b000000, 6'b100000, 1'b1, 1'b1);
    Flush = 1'b0; #1;
    vectors++;
    if ({ExValid, ExMultiCycle, Busy, Done} !== 4'b0000) begin
      miscompares++;
      $display("FAIL flush_div got=%b exp=0000", {ExValid, ExMultiCycle, Busy, Done});
    end
    for (int k = 0; k < DIV_LAT; k++) begin
      saw_done |= Done | Busy;
      drive(6'b000000, 6'b000000, 1'b0, 1'b0);
    end
    vectors++;
    if (saw_done !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_no_done got=%b exp=0", saw_done);
    end
    drive(6'b000000, 6'b100010, 1'b1, 1'b1);
    vectors++;
    if ({ExALUOp, ExValid} !== 5'b0100_0) begin
      miscompares++;
      $display("FAIL flush_drop got=%b exp=%b", {ExALUOp, ExValid}, 5'b0100_0);
    end
    Flush = 1'b0;
  endtask

  task automatic test_illegal();
    drive(6'b000000, 6'b100010, 1'b1, 1'b0);
    drive(6'b111111, 6'b000000, 1'b1, 1'b0);
    vectors++;
    if ({ExALUOp, ExValid} !== 5'b0010_1) begin
      miscompares++;
      $display("FAIL illegal_op got=%b exp=%b", {ExALUOp, ExValid}, 5'b0010_1);
    end
`ifdef ALUCTL_ILLEGAL_EN
    vectors++;
    if (ExIllegal !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_flag got=%b exp=1", ExIllegal);
    end
    drive(6'b000000, 6'b000000, 1'b0, 1'b1);
    vectors++;
    if (ExIllegal !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_flush got=%b exp=0", ExIllegal);
    end
`endif
    Flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      drive(6'b000000, rand_funct(1'b1), 1'b1, 1'b0);
      vectors++;
      if (ExValid !== 1'b1 || dut_pkt !== exp_pkt()) begin
        miscompares++;
        $display("FAIL back_to_back_%0d got=%b exp=%b", i, dut_pkt, exp_pkt());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(rand_opcode(), rand_funct(1'b0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 11) == 0));
      vectors++;
      if (dut_pkt !== exp_pkt()) begin
        miscompares++;
        $display("FAIL random_%0d got=%b exp=%b op=%b fn=%b", i, dut_pkt, exp_pkt(), Opcode, Funct);
      end
`ifdef ALUCTL_ILLEGAL_EN
      vectors++;
      if (ExIllegal !== m_ill) begin
        miscompares++;
        $display("FAIL random_illegal_%0d got=%b exp=%b", i, ExIllegal, m_ill);
      end
`endif
    end
    Flush = 1'b0;
    drive(6'b000000, 6'b000000, 1'b0, 1'b1);
    drive(6'b000000, 6'b000000, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_op();
    drive(6'b000000, 6'b011011, 1'b1, 1'b0);
    drive(6'b000000, 6'b000000, 1'b0, 1'b0);
    drive(6'b000000, 6'b000000, 1'b0, 1'b0);
    #2 Reset = 1'b1;
    #1;
    model_reset();
    vectors++;
    if (dut_pkt !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_mid_op got=%b exp=%b", dut_pkt, 8'h00);
    end
    @(posedge Clk); #2;
    Reset = 1'b0;
    @(posedge Clk); #1;
    drive(6'b000000, 6'b100000, 1'b1, 1'b0);
    vectors++;
    if (dut_pkt !== 8'b0010_1000) begin
      miscompares++;
      $display("FAIL reset_then_idle got=%b exp=%b", dut_pkt, 8'b0010_1000);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_mul();
    test_flush();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
